// File: rtl/tdm_demux2_if.sv
// tdm_demux2_if: signal bundle between a TDM serial source and the
// two-channel demultiplexer.
//   master : drives the bit strobe, serial data and frame sync;
//            observes the recovered words, valid pulses, lock and error.
//   slave  : the demultiplexer side (inputs en/din/fs, outputs the rest).
interface tdm_demux2_if #(
   parameter int W = 8
);
   logic         en;
   logic         din;
   logic         fs;
   logic [W-1:0] b0;
   logic [W-1:0] b1;
   logic         v0;
   logic         v1;
   logic         lock;
   logic         err;

   modport master (
      output en, din, fs,
      input  b0, b1, v0, v1, lock, err
   );

   modport slave (
      input  en, din, fs,
      output b0, b1, v0, v1, lock, err
   );
endinterface

// File: rtl/tdm_demux2.sv
// tdm_demux2: recovers two W-bit channels from a TDM serial stream.
// Each frame is slot 0 then slot 1, MSB first; fs marks the first bit of
// slot 0. Bits are taken only on cycles with en=1.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - tdm_demux2_if.slave: en/din/fs in; b0/b1 held words, v0/v1
//          one-cycle update pulses, lock (frame aligned), err (sync fault)
module tdm_demux2 #(
   parameter int W = 8
) (
   input  logic          clk,
   input  logic          rst,
   tdm_demux2_if.slave   bus
);
   localparam int CW = $clog2(W);

   localparam logic [0:0] ST_HUNT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [W-1:0]  shift_q, shift_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          slot_q,  slot_d;
   logic [W-1:0]  b0_q,    b0_d;
   logic [W-1:0]  b1_q,    b1_d;
   logic          v0_q,    v0_d;
   logic          v1_q,    v1_d;
   logic          lock_q,  lock_d;
   logic          err_q,   err_d;

   logic          at_start;
   logic          last_bit;
   logic [W-1:0]  shift_in;

   assign at_start = (cnt_q == '0) && !slot_q;
   assign last_bit = (cnt_q == CW'(W - 1));
   assign shift_in = {shift_q[W-2:0], bus.din};

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      slot_d  = slot_q;
      b0_d    = b0_q;
      b1_d    = b1_q;
      lock_d  = lock_q;
      // Pulses default low so they never stretch across idle strobes.
      v0_d    = 1'b0;
      v1_d    = 1'b0;
      err_d   = 1'b0;

      if (bus.en) begin
         if (state_q == ST_HUNT) begin
            if (bus.fs) begin
               shift_d = shift_in;
               cnt_d   = CW'(1);
               slot_d  = 1'b0;
               state_d = ST_RUN;
            end
         end else if (bus.fs && !at_start) begin
            // Early sync: drop the partial word and realign on this bit,
            // even if it would have completed a word.
            err_d   = 1'b1;
            lock_d  = 1'b0;
            shift_d = shift_in;
            cnt_d   = CW'(1);
            slot_d  = 1'b0;
         end else if (!bus.fs && at_start) begin
            // Missing sync: alignment lost, go back to hunting.
            err_d   = 1'b1;
            lock_d  = 1'b0;
            state_d = ST_HUNT;
         end else begin
            shift_d = shift_in;
            if (last_bit) begin
               if (!slot_q) begin
                  b0_d = shift_in;
                  v0_d = 1'b1;
               end else begin
                  b1_d   = shift_in;
                  v1_d   = 1'b1;
                  lock_d = 1'b1;
               end
               cnt_d  = '0;
               slot_d = !slot_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_HUNT;
         shift_q <= '0;
         cnt_q   <= '0;
         slot_q  <= 1'b0;
         b0_q    <= '0;
         b1_q    <= '0;
         v0_q    <= 1'b0;
         v1_q    <= 1'b0;
         lock_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         slot_q  <= slot_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         v0_q    <= v0_d;
         v1_q    <= v1_d;
         lock_q  <= lock_d;
         err_q   <= err_d;
      end
   end

   assign bus.b0   = b0_q;
   assign bus.b1   = b1_q;
   assign bus.v0   = v0_q;
   assign bus.v1   = v1_q;
   assign bus.lock = lock_q;
   assign bus.err  = err_q;
endmodule

// File: tb/tb_tdm_demux2.sv
module tb_tdm_demux2;
   localparam int W = 8;

   logic clk;
   logic rst;

   tdm_demux2_if #(.W(W)) bus ();

   tdm_demux2 #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: frame position (-1 = hunting) and the bits of the
   // current frame; words are assembled arithmetically from the bit array.
   int           m_pos;
   logic         m_bits [2*W];
   logic [W-1:0] m_b0, m_b1;
   logic         m_v0, m_v1, m_lock, m_err;
   int           v0_seen, v1_seen;

   typedef struct {
      logic         en;
      logic         din;
      logic         fs;
      logic [W-1:0] b0;
      logic [W-1:0] b1;
      logic         v0;
      logic         v1;
      logic         lock;
      logic         err;
   } vec_t;

   vec_t tbl [2*W];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] m_word(input int base);
      int v = 0;
      for (int i = 0; i < W; i++)
         v = v * 2 + int'(m_bits[base + i]);
      return W'(v);
   endfunction

   task automatic m_reset();
      m_pos = -1;
      m_b0 = '0; m_b1 = '0;
      m_v0 = 0; m_v1 = 0; m_lock = 0; m_err = 0;
      for (int i = 0; i < 2*W; i++) m_bits[i] = 1'b0;
   endtask

   task automatic m_step(input logic en, input logic din, input logic fs);
      m_v0 = 0; m_v1 = 0; m_err = 0;
      if (!en) return;
      if (m_pos < 0) begin
         if (fs) begin
            m_bits[0] = din;
            m_pos = 1;
         end
      end else if (fs && m_pos != 0) begin
         m_err = 1; m_lock = 0;
         m_bits[0] = din;
         m_pos = 1;
      end else if (!fs && m_pos == 0) begin
         m_err = 1; m_lock = 0;
         m_pos = -1;
      end else begin
         m_bits[m_pos] = din;
         if (m_pos == W - 1) begin
            m_b0 = m_word(0); m_v0 = 1;
         end else if (m_pos == 2*W - 1) begin
            m_b1 = m_word(W); m_v1 = 1; m_lock = 1;
         end
         m_pos = (m_pos + 1) % (2*W);
      end
   endtask

   task automatic cmp_model();
      chk("b0",   32'(bus.b0),   32'(m_b0));
      chk("b1",   32'(bus.b1),   32'(m_b1));
      chk("v0",   32'(bus.v0),   32'(m_v0));
      chk("v1",   32'(bus.v1),   32'(m_v1));
      chk("lock", 32'(bus.lock), 32'(m_lock));
      chk("err",  32'(bus.err),  32'(m_err));
   endtask

   // Drive one cycle, advance the model, then sample 1ns after the edge.
   task automatic apply(input logic en, input logic din, input logic fs);
      bus.en = en; bus.din = din; bus.fs = fs;
      @(posedge clk);
      m_step(en, din, fs);
      #1;
      if (bus.v0) v0_seen++;
      if (bus.v1) v1_seen++;
      cmp_model();
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n, input logic fs_first);
      for (int i = n - 1; i >= 0; i--)
         apply(1'b1, bits[i], fs_first && (i == n - 1));
   endtask

   logic [15:0] frame;

   initial begin
      bus.en = 0; bus.din = 0; bus.fs = 0;
      rst = 1'b1;
      m_reset();
      #12;
      chk("rst_b0",   32'(bus.b0),   0);
      chk("rst_b1",   32'(bus.b1),   0);
      chk("rst_lock", 32'(bus.lock), 0);
      chk("rst_v",    32'({bus.v0, bus.v1, bus.err}), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Table-driven: frame 0xA5 / 0x3C straight after reset.
      frame = 16'hA53C;
      for (int i = 0; i < 2*W; i++) begin
         tbl[i].en   = 1'b1;
         tbl[i].din  = frame[2*W - 1 - i];
         tbl[i].fs   = (i == 0);
         tbl[i].v0   = (i == W - 1);
         tbl[i].b0   = (i >= W - 1) ? 8'hA5 : 8'h00;
         tbl[i].v1   = (i == 2*W - 1);
         tbl[i].b1   = (i == 2*W - 1) ? 8'h3C : 8'h00;
         tbl[i].lock = (i == 2*W - 1);
         tbl[i].err  = 1'b0;
      end
      for (int i = 0; i < 2*W; i++) begin
         apply(tbl[i].en, tbl[i].din, tbl[i].fs);
         chk("tbl_b0",   32'(bus.b0),   32'(tbl[i].b0));
         chk("tbl_b1",   32'(bus.b1),   32'(tbl[i].b1));
         chk("tbl_v0",   32'(bus.v0),   32'(tbl[i].v0));
         chk("tbl_v1",   32'(bus.v1),   32'(tbl[i].v1));
         chk("tbl_lock", 32'(bus.lock), 32'(tbl[i].lock));
         chk("tbl_err",  32'(bus.err),  32'(tbl[i].err));
      end

      // Second frame keeps lock.
      send_bits(16'h0FF0, 16, 1'b1);
      chk("f2_b0",   32'(bus.b0), 32'h0F);
      chk("f2_b1",   32'(bus.b1), 32'hF0);
      chk("f2_lock", 32'(bus.lock), 1);

      // Asynchronous reset mid-slot, between clock edges.
      send_bits(16'h0005, 3, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("arst_b0",   32'(bus.b0),   0);
      chk("arst_b1",   32'(bus.b1),   0);
      chk("arst_lock", 32'(bus.lock), 0);
      chk("arst_v",    32'({bus.v0, bus.v1, bus.err}), 0);
      m_reset();
      #2 rst = 1'b0;
      v0_seen = 0; v1_seen = 0;
      send_bits(16'h00FF, 8, 1'b0);
      chk("hunt_nov", 32'(v0_seen + v1_seen), 0);
      chk("hunt_lock", 32'(bus.lock), 0);

      // Strobe gaps: en every third cycle, junk on idle cycles.
      v0_seen = 0; v1_seen = 0;
      frame = 16'hA53C;
      for (int i = 2*W - 1; i >= 0; i--) begin
         apply(1'b1, frame[i], i == 2*W - 1);
         apply(1'b0, 1'($urandom), 1'($urandom));
         apply(1'b0, 1'($urandom), 1'($urandom));
      end
      chk("gap_b0", 32'(bus.b0), 32'hA5);
      chk("gap_b1", 32'(bus.b1), 32'h3C);
      chk("gap_v0_width", 32'(v0_seen), 1);
      chk("gap_v1_width", 32'(v1_seen), 1);
      chk("gap_lock", 32'(bus.lock), 1);

      // Early fs three bits into slot 1.
      v1_seen = 0;
      send_bits(16'h0011, 8, 1'b1);
      send_bits(16'h0005, 3, 1'b0);
      apply(1'b1, 1'b1, 1'b1);
      chk("early_err",  32'(bus.err),  1);
      chk("early_lock", 32'(bus.lock), 0);
      chk("early_b1",   32'(bus.b1),   32'h3C);
      chk("early_nov1", 32'(v1_seen),  0);
      send_bits(16'h0001, 7, 1'b0);
      chk("resync_v0", 32'(bus.v0), 1);
      chk("resync_b0", 32'(bus.b0), 32'h81);
      send_bits(16'h0042, 8, 1'b0);
      chk("resync_v1",   32'(bus.v1),   1);
      chk("resync_b1",   32'(bus.b1),   32'h42);
      chk("resync_lock", 32'(bus.lock), 1);

      // Missing fs at the next frame start.
      apply(1'b1, 1'b1, 1'b0);
      chk("miss_err",  32'(bus.err),  1);
      chk("miss_lock", 32'(bus.lock), 0);
      v0_seen = 0; v1_seen = 0;
      send_bits(16'hFFFF, 16, 1'b0);
      chk("miss_nov", 32'(v0_seen + v1_seen), 0);
      chk("miss_b0",  32'(bus.b0), 32'h81);
      chk("miss_b1",  32'(bus.b1), 32'h42);
      send_bits(16'h5AC3, 16, 1'b1);
      chk("relock_b0",   32'(bus.b0),   32'h5A);
      chk("relock_b1",   32'(bus.b1),   32'hC3);
      chk("relock_lock", 32'(bus.lock), 1);

      // Early fs on the last bit of slot 0.
      send_bits(16'h0033, 7, 1'b1);
      apply(1'b1, 1'b0, 1'b1);
      chk("last_err", 32'(bus.err), 1);
      chk("last_v0",  32'(bus.v0),  0);
      chk("last_b0",  32'(bus.b0),  32'h5A);

      // Randomized traffic with mostly-correct framing and occasional faults.
      for (int n = 0; n < 4000; n++) begin
         logic e, d, f;
         e = ($urandom_range(0, 9) < 7);
         d = 1'($urandom);
         if (m_pos <= 0) f = ($urandom_range(0, 7) != 0);
         else            f = ($urandom_range(0, 39) == 0);
         apply(e, d, f);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/tdm_demux2.md
Name: tdm_demux2

Overview:
- Receive end of the two-input select path: recovers two W-bit channels from a time-division-multiplexed serial stream.
- The stream carries channel 0 then channel 1 per frame, MSB first, with a frame-sync marker on the first bit of each frame.
- Presents each channel on a held output register with a one-cycle valid pulse, and reports lock and sync errors.
- Sits downstream of the channel-select multiplexer.

Parameters:
- W, 8, bits per channel slot (W >= 2); frame length is 2*W bit strobes.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  bit strobe; din and fs are sampled only on cycles with en=1
- din  input  1  serial data bit, MSB of each slot first
- fs  input  1  frame sync; valid only with en=1; marks bit W-1 of slot 0
- b0  output  W  last complete channel-0 word, held
- b1  output  W  last complete channel-1 word, held
- v0  output  1  one-cycle pulse: b0 updated this cycle
- v1  output  1  one-cycle pulse: b1 updated this cycle
- lock  output  1  frame alignment established
- err  output  1  one-cycle pulse: sync violation detected

Behaviour:
- Reset (async, any time, including mid-frame):
  - b0=0, b1=0, v0=0, v1=0, lock=0, err=0.
  - State=HUNT; shift register, bit counter (0..W-1) and slot bit cleared.
- Cycles with en=0: no state change; v0, v1 and err return to 0 (pulses never stretch).
- HUNT:
  - en=1, fs=0: bit ignored.
  - en=1, fs=1: din loaded as first bit; bit_cnt=1, slot=0; go to RUN.
  - lock=0 throughout.
- RUN, on each en=1:
  - din shifted in at the LSB; bit_cnt increments.
  - When the received bit is bit W of the slot (bit_cnt==W-1 before the edge), the word is complete:
    - slot 0: b0 <= {shift[W-2:0], din}, v0=1 for exactly the next cycle.
    - slot 1: same for b1 and v1.
    - Then bit_cnt=0 and slot toggles.
  - Latency: b0/b1 and v0/v1 change on the clock edge that samples the last bit, so they are visible the following cycle.
- lock:
  - Set together with v1 on the first complete frame after entering RUN.
  - Remains 1 while in RUN without error.
- Early sync error: en=1 and fs=1 while not at frame start (bit_cnt!=0 or slot!=0).
  - err=1 for one cycle; lock=0.
  - Partial word discarded, no v pulse, even if this bit would have completed a word.
  - Immediate resync: this bit is bit 1 of slot 0 (bit_cnt=1, slot=0); stay in RUN.
- Missing sync error: en=1 and fs=0 at frame start (bit_cnt==0, slot==0) in RUN.
  - err=1 for one cycle; lock=0; bit discarded; go to HUNT.
- Normal frame start: en=1 and fs=1 at frame start is expected; no error, lock unchanged.
- b0/b1 hold their last value through errors, HUNT and en gaps; only reset clears them.
- v0 and v1 are never asserted in the same cycle. err and a v pulse are never asserted in the same cycle.

Test Plan:
- Reset: assert rst mid-slot, asynchronous to clk → all outputs 0 immediately. Release, then send 8 bits without fs → no v0/v1, lock=0.
- Normal frames, W=8, en=1 continuous:
  - fs with first bit; stream 0xA5 then 0x3C → b0=0xA5 with v0 pulse the cycle after bit 8; b1=0x3C with v1 pulse the cycle after bit 16; lock=1 from the v1 cycle.
  - Second frame 0x0F/0xF0 with fs → b0=0x0F, b1=0xF0, lock stays 1, err never set.
- Strobe gaps: same 0xA5/0x3C frame with en=1 every third cycle and toggling din on en=0 cycles → identical b0/b1 values; v0 and v1 are each exactly one clk wide.
- Early fs:
  - After 3 bits of slot 1, assert fs → err pulse, lock=0, no v1, b1 keeps its old value.
  - Following bits 0x81/0x42, counted from that fs bit → v0 with b0=0x81, v1 with b1=0x42, lock=1.
- Missing fs: locked stream; omit fs on the next frame start → err pulse, lock=0, HUNT. Subsequent bits ignored; b0/b1 unchanged until the next fs-marked frame decodes correctly.
- Early fs on the last bit of slot 0 → err pulse, no v0, b0 unchanged.
